seq_det_ctrl: RTL and testbench

//  Frame sequencer for the bit-serial 1011 detector (overlapping, Moore output one cycle after the bit).

---
 rtl/seq_det_ctrl_if.sv | 25 ++
 rtl/seq_det_ctrl.sv | 126 ++++++++++++
 tb/tb_seq_det_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_ctrl_if.sv
// Stream bundle for the 1011 frame sequencer: word input (s_*) and per-frame result output (m_*).
// The sequencer attaches to the slave modport; the word source and result sink attach to master.
interface seq_det_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [CNT_W-1:0]  m_count;
  logic              m_underrun;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_count, m_underrun
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_count, m_underrun
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Frame sequencer for a bit-serial 1011 detector: serialises words MSB-first, clears the
// detector at frame start, counts hits and reports one result per frame.
module seq_det_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic          clk,
  input  logic          rstn,
  seq_det_ctrl_if.slave bus,
  output logic          det_rstn,
  output logic          det_din,
  input  logic          det_dout,
  output logic          busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] cur, nxt;
  logic              cur_last, nxt_last, nxt_full, seen_last;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  count;
  logic              underrun;
  logic              s_rdy, s_fire;

  // Input is refused while a last word is already held, so nothing past the frame end is consumed.
  assign s_rdy  = (state == IDLE) || (state == FLUSH) ||
                  ((state == SHIFT) && !nxt_full && !cur_last && !seen_last);
  assign s_fire = bus.s_valid && s_rdy;

  assign bus.s_ready    = s_rdy;
  assign bus.m_valid    = (state == DONE);
  assign bus.m_count    = count;
  assign bus.m_underrun = underrun;
  assign det_rstn       = rstn && (state != CLR);
  assign det_din        = (state == SHIFT) ? cur[idx] : 1'b0;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (s_fire) state_nxt = CLR;
      CLR:   state_nxt = SHIFT;
      SHIFT: begin
        if (idx == '0) begin
          if (cur_last)                state_nxt = DRAIN;
          else if (nxt_full || s_fire) state_nxt = SHIFT;
          else                         state_nxt = DRAIN;
        end
      end
      DRAIN: state_nxt = DONE;
      DONE:  if (bus.m_ready) state_nxt = (underrun && !seen_last) ? FLUSH : IDLE;
      FLUSH: if (s_fire && bus.s_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // At a word boundary the next word (buffered or arriving right now) is loaded so the bit stream has no gap.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cur       <= '0;
      nxt       <= '0;
      cur_last  <= 1'b0;
      nxt_last  <= 1'b0;
      nxt_full  <= 1'b0;
      seen_last <= 1'b0;
      idx       <= '0;
      count     <= '0;
      underrun  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_fire) begin
            cur       <= bus.s_data;
            cur_last  <= bus.s_last;
            seen_last <= bus.s_last;
            nxt_full  <= 1'b0;
          end
        end
        CLR: begin
          count    <= '0;
          underrun <= 1'b0;
          idx      <= IDX_MAX;
        end
        SHIFT: begin
          if (idx == '0) begin
            idx <= IDX_MAX;
            if (!cur_last) begin
              if (nxt_full) begin
                cur      <= nxt;
                cur_last <= nxt_last;
                nxt_full <= 1'b0;
              end else if (s_fire) begin
                cur      <= bus.s_data;
                cur_last <= bus.s_last;
              end else begin
                underrun <= 1'b1;
              end
            end
          end else begin
            idx <= idx - 1'b1;
            if (s_fire) begin
              nxt      <= bus.s_data;
              nxt_last <= bus.s_last;
              nxt_full <= 1'b1;
            end
          end
          if (s_fire && bus.s_last) seen_last <= 1'b1;
        end
        default: ;
      endcase
      if (((state == SHIFT) || (state == DRAIN)) && det_dout && (count != CNT_MAX))
        count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: two instances (8-bit and 2-bit counters) run in lockstep on directed
// and random frames, each against a behavioural 1011 detector, checked against a string-match model.
module tb_seq_det_ctrl;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seq_det_ctrl_if #(.DATA_W(DATA_W), .CNT_W(8)) bus ();
  seq_det_ctrl_if #(.DATA_W(DATA_W), .CNT_W(2)) bus2 ();

  logic det_rstn, det_din, det_dout, busy;
  logic det_rstn2, det_din2, det_dout2, busy2;

  seq_det_ctrl #(.DATA_W(DATA_W), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .det_rstn(det_rstn), .det_din(det_din), .det_dout(det_dout), .busy(busy)
  );

  seq_det_ctrl #(.DATA_W(DATA_W), .CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .bus(bus2),
    .det_rstn(det_rstn2), .det_din(det_din2), .det_dout(det_dout2), .busy(busy2)
  );

  assign bus2.s_valid = bus.s_valid;
  assign bus2.s_data  = bus.s_data;
  assign bus2.s_last  = bus.s_last;
  assign bus2.m_ready = bus.m_ready;

  // Overlapping Moore 1011 detectors: flag is high the cycle after the final bit is clocked in.
  logic [3:0] hist, hist2;
  always @(posedge clk) begin
    if (!det_rstn)  hist  <= '0; else hist  <= {hist[2:0], det_din};
    if (!det_rstn2) hist2 <= '0; else hist2 <= {hist2[2:0], det_din2};
  end
  assign det_dout  = (hist  == 4'b1011);
  assign det_dout2 = (hist2 == 4'b1011);

  // Records the serial bits actually driven (detector out of reset) for the current frame.
  logic [63:0] cap;
  int          cap_n;
  int          cap_want = 0;
  always @(negedge clk) begin
    if (!busy) begin
      cap   <= '0;
      cap_n <= 0;
    end else if (det_rstn && (cap_n < cap_want)) begin
      cap   <= {cap[62:0], det_din};
      cap_n <= cap_n + 1;
    end
  end

  int   checks = 0;
  int   errors = 0;
  int   t0;
  logic [7:0] fw [8];
  int   fn;
  bit   fund;
  logic [7:0] flw [4];
  int   fln;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int refHits();
    bit b[$];
    int h = 0;
    for (int w = 0; w < fn; w++)
      for (int k = DATA_W - 1; k >= 0; k--) b.push_back(fw[w][k]);
    for (int i = 0; i + 3 < b.size(); i++)
      if (b[i] && !b[i+1] && b[i+2] && b[i+3]) h++;
    return h;
  endfunction

  function automatic logic [63:0] refStream();
    logic [63:0] s = '0;
    for (int w = 0; w < fn; w++) s = {s[55:0], fw[w]};
    return s;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic sendWord(input logic [7:0] d, input logic l, output int ok);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.s_ready) begin
        ok = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic applyStimulus();
    int ok;
    cap_want = fn * DATA_W;
    for (int w = 0; w < fn; w++) begin
      sendWord(fw[w], (!fund && (w == fn - 1)), ok);
      checkOutput("s_handshake", ok, 1);
      if (w == 0) begin
        t0 = cyc;
        checkOutput("clr_det_rstn", det_rstn, 0);
        checkOutput("clr_s_ready", bus.s_ready, 0);
      end
    end
  endtask

  task automatic finishFrame(input string tag, input int hold);
    int hits, ok, e8, e2;
    hits = refHits();
    e8 = (hits > 255) ? 255 : hits;
    e2 = (hits > 3) ? 3 : hits;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.m_valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_done_seen"}, ok, 1);
    checkOutput({tag, "_latency"}, cyc - t0, fn * DATA_W + 2);
    checkOutput({tag, "_valid2"}, bus2.m_valid, 1);
    checkOutput({tag, "_count8"}, bus.m_count, e8);
    checkOutput({tag, "_count2"}, bus2.m_count, e2);
    checkOutput({tag, "_underrun"}, bus.m_underrun, fund);
    checkOutput({tag, "_underrun2"}, bus2.m_underrun, fund);
    checkOutput({tag, "_stream"}, cap, refStream());
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, bus.m_valid, 1);
      checkOutput({tag, "_hold_count"}, bus.m_count, e8);
      checkOutput({tag, "_hold_s_ready"}, bus.s_ready, 0);
      checkOutput({tag, "_hold_s_ready2"}, bus2.s_ready, 0);
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, bus.m_valid, 0);
    if (fund) begin
      checkOutput({tag, "_flush_busy"}, busy, 1);
      checkOutput({tag, "_flush_s_ready"}, bus.s_ready, 1);
      for (int i = 0; i < fln; i++) begin
        sendWord(flw[i], (i == fln - 1), ok);
        checkOutput({tag, "_flush_hs"}, ok, 1);
      end
    end
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ok, r;
    rstn        = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_m_valid", bus.m_valid, 0);
    checkOutput("reset_det_rstn", det_rstn, 0);
    checkOutput("reset_det_din", det_din, 0);
    checkOutput("reset_count", bus.m_count, 0);
    checkOutput("reset_underrun", bus.m_underrun, 0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("idle_s_ready", bus.s_ready, 1);
    checkOutput("idle_det_rstn", det_rstn, 1);

    $display("[TB] T1 single 0x0B");
    fn = 1; fund = 0; fw[0] = 8'h0B;
    applyStimulus(); finishFrame("t1", 0);

    $display("[TB] T2 overlapping 0x5B");
    fn = 1; fund = 0; fw[0] = 8'h5B;
    applyStimulus(); finishFrame("t2", 1);

    $display("[TB] T3 boundary-spanning 0x01,0x60");
    fn = 2; fund = 0; fw[0] = 8'h01; fw[1] = 8'h60;
    applyStimulus(); finishFrame("t3", 0);

    $display("[TB] T4 saturation 0xBB,0xBB");
    fn = 2; fund = 0; fw[0] = 8'hBB; fw[1] = 8'hBB;
    applyStimulus(); finishFrame("t4", 5);

    $display("[TB] T5 underrun then flush");
    fn = 1; fund = 1; fw[0] = 8'h0B;
    fln = 2; flw[0] = 8'hFF; flw[1] = 8'h0B;
    applyStimulus(); finishFrame("t5", 2);
    fn = 1; fund = 0; fw[0] = 8'h0B;
    applyStimulus(); finishFrame("t5_next", 0);

    $display("[TB] T6 reset mid-frame");
    cap_want = 8;
    sendWord(8'h0B, 1'b1, ok);
    checkOutput("t6_hs", ok, 1);
    repeat (3) @(negedge clk);
    checkOutput("t6_busy_before", busy, 1);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_busy2", busy2, 0);
    checkOutput("t6_m_valid", bus.m_valid, 0);
    checkOutput("t6_det_rstn", det_rstn, 0);
    rstn = 1'b1;
    @(negedge clk);
    fn = 1; fund = 0; fw[0] = 8'h0B;
    applyStimulus(); finishFrame("t6_next", 0);

    $display("[TB] random frames");
    for (int f = 0; f < 24; f++) begin
      fn   = $urandom_range(1, 4);
      fund = ($urandom_range(0, 3) == 0);
      for (int w = 0; w < fn; w++) begin
        r = $urandom_range(0, 3);
        case (r)
          0:       fw[w] = 8'hBB;
          1:       fw[w] = 8'h2D;
          default: fw[w] = 8'($urandom);
        endcase
      end
      fln = $urandom_range(1, 3);
      for (int i = 0; i < fln; i++) flw[i] = 8'($urandom);
      applyStimulus();
      finishFrame("rnd", $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
